calc_controller: RTL

Sequencing controller for the calculator datapath: on a start pulse it walks a range of 64-bit SRAM words, adds the two 32-bit operands packed in each word, packs two 32-bit sums per 64-bit result word, and writes results back to a second SRAM region. It sits between the host/testbench control (start, address ranges) and the single-port SRAM. It owns the SRAM port for the whole operation and reports completion, overflow and range errors.

---
 rtl/calculator_pkg.sv | 18 +
 rtl/calc_controller_if.sv | 34 +++
 rtl/adder32.sv | 13 +
 rtl/calc_controller.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/calculator_pkg.sv
// Shared types and sizes for the calculator datapath and its controller.
package calculator_pkg;

  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 2 * DATA_W;
  localparam int ADDR_W        = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RWAIT,
    S_ADD,
    S_WSET,
    S_WRITE,
    S_END
  } state_t;

endpackage

// File: rtl/calc_controller_if.sv
// Host control and single-port SRAM bus seen by the calculator controller.
interface calc_controller_if;
  import calculator_pkg::*;

  // Host side
  logic                     start;
  logic [ADDR_W-1:0]        read_start_addr;
  logic [ADDR_W-1:0]        read_end_addr;
  logic [ADDR_W-1:0]        write_start_addr;
  logic                     busy;
  logic                     done;
  logic                     overflow;
  logic                     error;

  // SRAM side
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [MEM_WORD_SIZE-1:0] mem_wdata;
  logic [MEM_WORD_SIZE-1:0] mem_rdata;

  // The controller drives the SRAM port and the status flags.
  modport master (
    input  start, read_start_addr, read_end_addr, write_start_addr, mem_rdata,
    output busy, done, overflow, error, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Host plus SRAM: supplies control and read data, observes everything else.
  modport slave (
    output start, read_start_addr, read_end_addr, write_start_addr, mem_rdata,
    input  busy, done, overflow, error, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/adder32.sv
// Combinational DATA_W adder with carry-out; the controller registers the result.
module adder32
  import calculator_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/calc_controller.sv
// Sequencing controller: reads operand pairs from SRAM, adds them, packs two
// sums per result word and writes the results back to a second SRAM region.
module calc_controller
  import calculator_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  calc_controller_if.master bus
);

  state_t                   r_state;
  state_t                   w_next_state;

  logic [ADDR_W-1:0]        r_rd_ptr;
  logic [ADDR_W-1:0]        r_wr_ptr;
  logic [ADDR_W-1:0]        r_read_end;
  logic                     r_slot;
  logic [MEM_WORD_SIZE-1:0] r_op;
  logic [DATA_W-1:0]        r_sum;
  logic [MEM_WORD_SIZE-1:0] r_buf;
  logic                     r_overflow;
  logic                     r_error;

  logic [DATA_W-1:0]        w_sum;
  logic                     w_carry;
  logic                     w_last_rd;
  logic                     w_range_bad;

  logic                     w_mem_en;
  logic                     w_mem_we;
  logic [ADDR_W-1:0]        w_mem_addr;
  logic [MEM_WORD_SIZE-1:0] w_mem_wdata;
  logic                     w_done;

  adder32 u_adder (
    .i_a     (r_op[DATA_W-1:0]),
    .i_b     (r_op[MEM_WORD_SIZE-1:DATA_W]),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_last_rd   = (r_rd_ptr == r_read_end);
  assign w_range_bad = (bus.read_end_addr < bus.read_start_addr);

  // State register plus all datapath registers, advanced per state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and process ordering cannot change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_read_end <= '0;
      r_slot     <= 1'b0;
      r_op       <= '0;
      r_sum      <= '0;
      r_buf      <= '0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rd_ptr   <= bus.read_start_addr;
            r_wr_ptr   <= bus.write_start_addr;
            r_read_end <= bus.read_end_addr;
            r_slot     <= 1'b0;
            r_buf      <= '0;
            r_overflow <= 1'b0;
            r_error    <= w_range_bad;
          end
        end
        S_RWAIT: r_op <= bus.mem_rdata;
        S_ADD: begin
          r_sum <= w_sum;
          if (w_carry) r_overflow <= 1'b1;
        end
        S_WSET: begin
          if (!r_slot) r_buf[DATA_W-1:0]             <= r_sum;
          else         r_buf[MEM_WORD_SIZE-1:DATA_W] <= r_sum;
          if (!r_slot && !w_last_rd) begin
            r_slot   <= 1'b1;
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
          end
        end
        S_WRITE: begin
          if (!w_last_rd) begin
            // Result pointer wraps naturally at 2^ADDR_W; read range was checked.
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_slot   <= 1'b0;
            r_buf    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and registered-state output decode.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_mem_en     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = w_range_bad ? S_END : S_READ;
      S_READ: begin
        w_mem_en     = 1'b1;
        w_mem_addr   = r_rd_ptr;
        w_next_state = S_RWAIT;
      end
      S_RWAIT: w_next_state = S_ADD;
      S_ADD:   w_next_state = S_WSET;
      S_WSET:  w_next_state = (r_slot || w_last_rd) ? S_WRITE : S_READ;
      S_WRITE: begin
        w_mem_en     = 1'b1;
        w_mem_we     = 1'b1;
        w_mem_addr   = r_wr_ptr;
        w_mem_wdata  = r_buf;
        w_next_state = w_last_rd ? S_END : S_READ;
      end
      S_END: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.done      = w_done;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.overflow  = r_overflow;
  assign bus.error     = r_error;

endmodule
